// File: rtl/param_das_beamformer.sv
// Delay-and-sum beamformer: per-channel circular delay lines, summed across all channels.
// Latency: out_valid 2 cycles after an in_valid accepted in RUN (read stage + adder stage).
// Backpressure: none; one sample per cycle in FILL/RUN, in_valid ignored in IDLE/DRAIN.
// Build option: define DAS_AVERAGE_EN to output the channel mean instead of the full sum.
module param_das_beamformer #(
    parameter int  NUM_CH   = 4,
    parameter int  SAMPLE_W = 12,
    parameter int  DELAY_W  = 8,
    localparam int CH_LOG2  = $clog2(NUM_CH),
    localparam int OUT_W    = SAMPLE_W + CH_LOG2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
    input  logic                       dly_wr_en,
    input  logic [CH_LOG2-1:0]         dly_wr_ch,
    input  logic [DELAY_W-1:0]         dly_wr_val,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       busy
);

    localparam int DEPTH = 1 << DELAY_W;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [DELAY_W-1:0]      wr_ptr;
    logic [DELAY_W-1:0]      fill_cnt;
    logic [DELAY_W:0]        fill_cnt_nx;
    logic [DELAY_W-1:0]      max_dly;
    logic [DELAY_W-1:0]      tbl_max;
    logic [DELAY_W-1:0]      delay_tbl [NUM_CH];
    logic                    drain_cnt;
    logic                    accept;
    logic                    go;
    logic                    fill_done;
    logic                    pipe_vld;
    logic [NUM_CH*OUT_W-1:0] ext_flat;
    logic signed [OUT_W-1:0] sum;
    logic signed [OUT_W-1:0] sum_sel;

    assign accept = in_valid && ((state_q == FILL) || (state_q == RUN));
    // stop wins over a simultaneous start, so the block stays in IDLE
    assign go     = start && !stop;
    assign busy   = (state_q != IDLE);

    // FILL ends once enough history exists for the largest delay; a zero
    // maximum still needs one sample so FILL is never empty.
    assign fill_cnt_nx = {1'b0, fill_cnt} + (DELAY_W+1)'(1);
    assign fill_done   = (fill_cnt_nx >= {1'b0, max_dly});

    // Largest delay-table entry, captured into max_dly on the start cycle
    always_comb begin
        tbl_max = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (delay_tbl[k] > tbl_max) tbl_max = delay_tbl[k];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = FILL;
            FILL:    if (stop) state_d = DRAIN;
                     else if (accept && fill_done) state_d = RUN;
            RUN:     if (stop) state_d = DRAIN;
            DRAIN:   if (drain_cnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write pointer, fill counter, captured max delay and drain timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            max_dly   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + DELAY_W'(1);
            if ((state_q == IDLE) && go) begin
                fill_cnt <= '0;
                max_dly  <= tbl_max;
            end else if ((state_q == FILL) && accept) begin
                fill_cnt <= fill_cnt_nx[DELAY_W-1:0];
            end
            drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Delay table: writable only while IDLE so delays stay fixed during an acquisition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) delay_tbl[k] <= '0;
        end else if ((state_q == IDLE) && dly_wr_en) begin
            delay_tbl[dly_wr_ch] <= dly_wr_val;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [SAMPLE_W-1:0] line_mem [DEPTH];
        logic [SAMPLE_W-1:0] cur_smp;
        logic [SAMPLE_W-1:0] rd_smp;
        logic [DELAY_W-1:0]  rd_addr;

        assign cur_smp = in_data[k*SAMPLE_W +: SAMPLE_W];
        assign rd_addr = wr_ptr - delay_tbl[k];

        // Circular delay line, read-before-write; a zero delay would read the
        // slot being overwritten, so the incoming sample is forwarded instead.
        always_ff @(posedge clk) begin
            if (accept) begin
                line_mem[wr_ptr] <= cur_smp;
                rd_smp           <= (delay_tbl[k] == '0) ? cur_smp : line_mem[rd_addr];
            end
        end

        assign ext_flat[k*OUT_W +: OUT_W] = {{CH_LOG2{rd_smp[SAMPLE_W-1]}}, rd_smp};
    end

    // Channel sum; OUT_W has CH_LOG2 guard bits so it cannot overflow
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = sum + $signed(ext_flat[k*OUT_W +: OUT_W]);
        end
    end

`ifdef DAS_AVERAGE_EN
    assign sum_sel = sum >>> CH_LOG2;
`else
    assign sum_sel = sum;
`endif

    // Read-stage valid: only samples accepted in RUN produce output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_vld <= 1'b0;
        else        pipe_vld <= accept && (state_q == RUN);
    end

    // Registered adder output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= pipe_vld;
            if (pipe_vld) out_data <= sum_sel;
        end
    end

endmodule

// File: tb/tb_param_das_beamformer.sv
module tb_param_das_beamformer;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 12;
    localparam int DELAY_W  = 8;
    localparam int CH_LOG2  = 2;
    localparam int OUT_W    = 14;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic                       stop = 1'b0;
    logic                       in_valid = 1'b0;
    logic [NUM_CH*SAMPLE_W-1:0] in_data = '0;
    logic                       dly_wr_en = 1'b0;
    logic [CH_LOG2-1:0]         dly_wr_ch = '0;
    logic [DELAY_W-1:0]         dly_wr_val = '0;
    logic                       out_valid;
    logic signed [OUT_W-1:0]    out_data;
    logic                       busy;

    param_das_beamformer #(
        .NUM_CH  (NUM_CH),
        .SAMPLE_W(SAMPLE_W),
        .DELAY_W (DELAY_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .dly_wr_en (dly_wr_en),
        .dly_wr_ch (dly_wr_ch),
        .dly_wr_val(dly_wr_val),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int exp_q[$];
    int dly_m [NUM_CH];
    int hist [NUM_CH][0:511];
    int n_acc    = 0;
    int fill_len = 1;
    int tot_acc  = 0;
    bit tbl_mode = 1'b0;
    int tbl_exp  = 0;

    typedef struct {
        logic [47:0] dat;
        int          exp_sum;
        int          exp_avg;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every out_valid pops one expected value
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else                   check("out_data", int'(out_data), exp_q.pop_front());
        end
    end

    function automatic logic [47:0] pack4(input int a, input int b, input int c, input int d);
        logic [11:0] pa, pb, pc, pd;
        pa = a[11:0];
        pb = b[11:0];
        pc = c[11:0];
        pd = d[11:0];
        return {pd, pc, pb, pa};
    endfunction

    function automatic logic [47:0] rand4();
        return pack4(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                     int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 0; stop = 0; in_valid = 0; dly_wr_en = 0;
        end
    endtask

    task automatic write_dly(input int ch, input int val, input bit upd);
        @(posedge clk); #1;
        start = 0; stop = 0; in_valid = 0;
        dly_wr_en = 1; dly_wr_ch = ch[1:0]; dly_wr_val = val[7:0];
        if (upd) dly_m[ch] = val;
    endtask

    task automatic set_delays(input int a, input int b, input int c, input int d);
        write_dly(0, a, 1'b1);
        write_dly(1, b, 1'b1);
        write_dly(2, c, 1'b1);
        write_dly(3, d, 1'b1);
        idle(1);
    endtask

    task automatic start_acq();
        int mx;
        mx = 0;
        for (int k = 0; k < NUM_CH; k++) if (dly_m[k] > mx) mx = dly_m[k];
        fill_len = (mx == 0) ? 1 : mx;
        n_acc = 0;
        @(posedge clk); #1;
        start = 1; stop = 0; in_valid = 0; dly_wr_en = 0;
    endtask

    // Drive one accepted sample and push its expected output if it lands in RUN
    task automatic send(input logic [47:0] d, input bit stp);
        int s;
        @(posedge clk); #1;
        start = 0; dly_wr_en = 0; stop = stp; in_valid = 1; in_data = d;
        for (int k = 0; k < NUM_CH; k++) hist[k][n_acc] = int'($signed(d[k*SAMPLE_W +: SAMPLE_W]));
        if (n_acc >= fill_len) begin
            s = 0;
            for (int k = 0; k < NUM_CH; k++) s += hist[k][n_acc - dly_m[k]];
            if (tbl_mode) exp_q.push_back(tbl_exp);
            else begin
`ifdef DAS_AVERAGE_EN
                exp_q.push_back(s >>> CH_LOG2);
`else
                exp_q.push_back(s);
`endif
            end
        end
        n_acc++;
        tot_acc++;
    endtask

    task automatic end_acq();
        @(posedge clk); #1;
        start = 0; stop = 1; in_valid = 0; dly_wr_en = 0;
        idle(4);
    endtask

    initial begin
        int n0;
        int k;

        vt[0] = '{pack4(100, 100, 100, 100),       400,   100};
        vt[1] = '{pack4(-2048, -2048, -2048, -2048), -8192, -2048};
        vt[2] = '{pack4(2047, 2047, 2047, 2047),    8188,  2047};
        vt[3] = '{pack4(1, -1, 5, -7),              -2,    -1};
        vt[4] = '{pack4(-1, -1, -1, 0),             -3,    -1};
        vt[5] = '{pack4(300, -200, 50, -25),        125,   31};
        for (int i = 0; i < NUM_CH; i++) dly_m[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1;
        idle(2);

        // Constant-vector table, all delays 0
        tbl_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_delays(0, 0, 0, 0);
            start_acq();
`ifdef DAS_AVERAGE_EN
            tbl_exp = vt[i].exp_avg;
`else
            tbl_exp = vt[i].exp_sum;
`endif
            for (int j = 0; j < 4; j++) send(vt[i].dat, 1'b0);
            end_acq();
        end
        tbl_mode = 1'b0;

        // Start and stop together in IDLE: stays idle; in_valid in IDLE ignored
        @(posedge clk); #1;
        start = 1; stop = 1;
        idle(1);
        check("start_stop_idle", int'(busy), 0);
        @(posedge clk); #1;
        in_valid = 1; in_data = rand4();
        idle(4);

        // Two-cycle latency on an isolated RUN sample
        set_delays(0, 0, 0, 0);
        start_acq();
        send(pack4(7, 7, 7, 7), 1'b0);
        idle(2);
        check("busy_run", int'(busy), 1);
        send(pack4(100, 100, 100, 100), 1'b0);
        @(negedge clk); check("lat_cycle0", int'(out_valid), 0);
        idle(1);
        @(negedge clk); check("lat_cycle1", int'(out_valid), 0);
        idle(1);
        @(negedge clk); check("lat_cycle2", int'(out_valid), 1);
        idle(1);
        @(negedge clk); check("lat_cycle3", int'(out_valid), 0);
        end_acq();

        // Impulse with staggered delays: FILL takes 3 samples, 7 outputs
        set_delays(0, 1, 2, 3);
        start_acq();
        n0 = n_out;
        for (int j = 0; j < 10; j++) send((j == 5) ? pack4(1000, 1000, 1000, 1000) : 48'd0, 1'b0);
        end_acq();
        check("impulse_out_count", n_out - n0, 7);

        // Filler run so the wrap run's RUN phase sees wr_ptr roll 255->0
        set_delays(0, 0, 0, 0);
        start_acq();
        k = (236 - (tot_acc % 256) + 256) % 256;
        if (k == 0) k = 256;
        for (int j = 0; j < k; j++) send(rand4(), 1'b0);
        end_acq();

        // 300 samples, channel 0 delayed by 255
        set_delays(255, 0, 0, 0);
        start_acq();
        n0 = n_out;
        for (int j = 0; j < 300; j++)
            send(pack4(j - 150, int'($urandom_range(0, 200)) - 100, (j % 7) - 3, -j), 1'b0);
        end_acq();
        check("wrap_out_count", n_out - n0, 45);

        // Delay write and start ignored in RUN; stop lets at most 2 outputs out
        set_delays(2, 0, 0, 0);
        start_acq();
        for (int j = 0; j < 4; j++) send(rand4(), 1'b0);
        write_dly(0, 0, 1'b0);
        send(rand4(), 1'b0);
        send(rand4(), 1'b0);
        @(posedge clk); #1;
        start = 1; in_valid = 0; dly_wr_en = 0;
        for (int j = 0; j < 3; j++) send(rand4(), 1'b0);
        send(rand4(), 1'b1);
        idle(1);
        #1;
        n0 = n_out;
        check("busy_drain", int'(busy), 1);
        idle(4);
        check("post_stop_outputs", n_out - n0, 2);
        check("busy_after_drain", int'(busy), 0);

        // Reset mid-RUN with samples in flight
        set_delays(1, 1, 1, 1);
        start_acq();
        for (int j = 0; j < 6; j++) send(rand4(), 1'b0);
        #2;
        rst_n = 0;
        exp_q.delete();
        #1;
        check("midrun_rst_out_valid", int'(out_valid), 0);
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_out_data", int'(out_data), 0);
        in_valid = 0; start = 0; stop = 0; dly_wr_en = 0;
        tot_acc = 0;
        for (int i = 0; i < NUM_CH; i++) dly_m[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        n0 = n_out;
        idle(3);
        check("post_reset_silent", n_out - n0, 0);

        // Delay table must read as all-zero after reset
        start_acq();
        n0 = n_out;
        for (int j = 0; j < 5; j++) send(rand4(), 1'b0);
        end_acq();
        check("post_reset_out_count", n_out - n0, 4);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_das_beamformer.md
PARAM_DAS_BEAMFORMER -- requirements
Module: param_das_beamformer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of channels, a power of two, 2..16.
REQ-002 SHALL have parameter SAMPLE_W, default 12: signed two's-complement sample width.
REQ-003 SHALL have parameter DELAY_W, default 8: delay width; per-channel delay line depth is 2^DELAY_W.
REQ-004 SHALL have derived localparam CH_LOG2 = log2(NUM_CH) and OUT_W = SAMPLE_W+CH_LOG2.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  pulse; begins acquisition from IDLE.
REQ-008 SHALL have port stop  input  1  pulse; ends acquisition.
REQ-009 SHALL have port in_valid  input  1  qualifies in_data.
REQ-010 SHALL have port in_data  input  NUM_CH*SAMPLE_W  packed samples; channel k in bits [k*SAMPLE_W +: SAMPLE_W].
REQ-011 SHALL have port dly_wr_en  input  1  delay-table write strobe.
REQ-012 SHALL have port dly_wr_ch  input  CH_LOG2  channel index for the write.
REQ-013 SHALL have port dly_wr_val  input  DELAY_W  delay in samples.
REQ-014 SHALL have port out_valid  output  1  one-cycle strobe qualifying out_data.
REQ-015 SHALL have port out_data  output  OUT_W  signed beamformed sum.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL have FSM states IDLE, FILL, RUN, DRAIN.
- IDLE->FILL on start.
- FILL->RUN when fill_cnt equals max_dly.
- FILL/RUN->DRAIN on stop.
- DRAIN->IDLE after 2 cycles.
REQ-018 SHALL capture max_dly, the largest delay-table entry, on the start cycle; with max_dly=0, FILL lasts exactly one accepted sample.
REQ-019 SHALL keep one 2^DELAY_W-entry circular buffer per channel and write each in_valid sample there at wr_ptr, which increments modulo 2^DELAY_W (wraps 255->0 at default).
REQ-020 SHALL read channel k at address (wr_ptr - delay[k]) mod 2^DELAY_W in the same accepting cycle, using synchronous read-before-write semantics.
REQ-021 SHALL sign-extend each read sample to OUT_W and sum the channels in one registered adder stage.
REQ-022 SHALL make out_valid rise exactly 2 cycles after an in_valid accepted in RUN; samples accepted in FILL produce no output.
REQ-023 SHALL ignore in_valid in IDLE and DRAIN.
REQ-024 SHALL update delay[dly_wr_ch] on dly_wr_en only in IDLE and ignore it in every other state.
REQ-025 SHALL ignore start when not in IDLE.
REQ-026 SHALL give stop priority when start and stop are asserted together in IDLE, leaving the block in IDLE.
REQ-027 SHALL let in-flight samples complete during DRAIN, so at most 2 out_valid pulses follow stop.
REQ-028 SHALL accept back-to-back in_valid (one sample per cycle) with no stall.

Reset
REQ-029 SHALL on rst_n low set state=IDLE, wr_ptr=0, fill_cnt=0, max_dly=0, delay table to all 0, out_valid=0, out_data=0, busy=0, and clear pipeline valids.
REQ-030 SHALL produce no out_valid for data accepted before reset when reset is asserted mid-RUN; buffer contents need not be cleared.

Configuration
REQ-031 SHALL, with macro DAS_AVERAGE_EN defined, arithmetic-shift the sum right by CH_LOG2 before registering it, so out_data is the sign-extended channel mean.
REQ-032 SHALL, with DAS_AVERAGE_EN undefined, output the full-precision sum; port widths are identical in both builds.

Verification
REQ-033 SHALL cover: all delays 0, NUM_CH=4, every channel =100 per sample -> out_data=400 (100 with DAS_AVERAGE_EN), 2-cycle latency.
REQ-034 SHALL cover: delays {0,1,2,3}, impulse 1000 on all channels at sample n -> outputs 1000 at n, n+1, n+2, n+3 (one channel each), FILL lasting 3 samples.
REQ-035 SHALL cover: all channels -2048 (12-bit minimum), delays 0 -> out_data=-8192 with no overflow.
REQ-036 SHALL cover: 300 continuous samples with delay 255 on channel 0 -> wrap-around with correct 255-sample lag after wr_ptr passes 255->0.
REQ-037 SHALL cover: dly_wr_en in RUN -> table unchanged; start in RUN ignored; stop -> at most 2 further out_valid, then busy=0.
REQ-038 SHALL cover: rst_n low mid-RUN with samples in flight -> out_valid=0 immediately, IDLE, delays read back as 0.
